// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard controller for the 5-stage RV32I pipeline. Each cycle it drives the
// clear and active-low enable of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
// registers and of the PC. It handles the post-reset flush, load-use stalls,
// branch/jump redirects and multi-cycle data-memory waits (with a sticky
// watchdog). It also keeps saturating stall/flush performance counters.
//
// Ports
//   i_hz_clk, i_hz_rst        clock (rising edge), async active-high reset
//   i_hz_id_rs1/rs2           source register indices of the ID instruction
//   i_hz_id_uses_rs1/rs2      ID instruction really reads rs1/rs2
//   i_hz_ex_rd                destination register of the EX instruction
//   i_hz_ex_is_load           EX instruction is a load
//   i_hz_ex_redirect          branch taken / jump resolved in EX
//   i_hz_dmem_req/ready       MEM stage access pending / completing
//   o_hz_*_en_n               PC and stage enables, active-low
//   o_hz_*_clr                synchronous stage clears (override enable)
//   o_hz_state                INIT=0, RUN=1, MEM_WAIT=2
//   o_hz_stall_cnt/flush_cnt  saturating performance counters
//   o_hz_mem_timeout          sticky watchdog flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic             i_hz_clk,
  input  logic             i_hz_rst,
  input  logic [4:0]       i_hz_id_rs1,
  input  logic [4:0]       i_hz_id_rs2,
  input  logic             i_hz_id_uses_rs1,
  input  logic             i_hz_id_uses_rs2,
  input  logic [4:0]       i_hz_ex_rd,
  input  logic             i_hz_ex_is_load,
  input  logic             i_hz_ex_redirect,
  input  logic             i_hz_dmem_req,
  input  logic             i_hz_dmem_ready,
  output logic             o_hz_pc_en_n,
  output logic             o_hz_ifid_en_n,
  output logic             o_hz_idex_en_n,
  output logic             o_hz_exmem_en_n,
  output logic             o_hz_memwb_en_n,
  output logic             o_hz_ifid_clr,
  output logic             o_hz_idex_clr,
  output logic             o_hz_exmem_clr,
  output logic             o_hz_memwb_clr,
  output logic [1:0]       o_hz_state,
  output logic [CNT_W-1:0] o_hz_stall_cnt,
  output logic [CNT_W-1:0] o_hz_flush_cnt,
  output logic             o_hz_mem_timeout
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);

  state_t           r_state;
  state_t           w_nextState;
  logic [IW-1:0]    r_initCnt;
  logic [WW-1:0]    r_wait;
  logic [WW-1:0]    w_waitNext;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             r_timeout;

  logic w_freeze;
  logic w_loadUse;
  logic w_redirTaken;
  logic w_pcEnN, w_ifidEnN, w_idexEnN, w_exmemEnN, w_memwbEnN;
  logic w_ifidClr, w_idexClr, w_exmemClr, w_memwbClr;

  // A load writing x0 never creates a real dependency.
  assign w_freeze  = i_hz_dmem_req && !i_hz_dmem_ready;
  assign w_loadUse = i_hz_ex_is_load && (i_hz_ex_rd != 5'd0) &&
                     ((i_hz_id_uses_rs1 && (i_hz_id_rs1 == i_hz_ex_rd)) ||
                      (i_hz_id_uses_rs2 && (i_hz_id_rs2 == i_hz_ex_rd)));

  // Mealy control: hazard priority is freeze > redirect > load-use. A redirect
  // hidden behind a freeze is picked up later because EX stays frozen.
  always_comb begin
    w_nextState  = r_state;
    w_redirTaken = 1'b0;
    w_pcEnN      = 1'b0;
    w_ifidEnN    = 1'b0;
    w_idexEnN    = 1'b0;
    w_exmemEnN   = 1'b0;
    w_memwbEnN   = 1'b0;
    w_ifidClr    = 1'b0;
    w_idexClr    = 1'b0;
    w_exmemClr   = 1'b0;
    w_memwbClr   = 1'b0;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_freeze) begin
          w_pcEnN    = 1'b1;
          w_ifidEnN  = 1'b1;
          w_idexEnN  = 1'b1;
          w_exmemEnN = 1'b1;
          w_memwbClr = 1'b1;
        end else if (i_hz_ex_redirect) begin
          w_redirTaken = 1'b1;
          w_ifidClr    = 1'b1;
          w_idexClr    = 1'b1;
        end else if (w_loadUse) begin
          w_pcEnN   = 1'b1;
          w_ifidEnN = 1'b1;
          w_idexClr = 1'b1;
        end
        if (r_state == ST_RUN && w_freeze) begin
          w_nextState = ST_MEM_WAIT;
        end else if (r_state == ST_MEM_WAIT && i_hz_dmem_ready) begin
          w_nextState = ST_RUN;
        end
      end
      default: begin
        // INIT (and the unused encoding) holds the whole pipeline cleared.
        w_pcEnN    = 1'b1;
        w_ifidEnN  = 1'b1;
        w_idexEnN  = 1'b1;
        w_exmemEnN = 1'b1;
        w_memwbEnN = 1'b1;
        w_ifidClr  = 1'b1;
        w_idexClr  = 1'b1;
        w_exmemClr = 1'b1;
        w_memwbClr = 1'b1;
        if (r_state != ST_INIT || r_initCnt == '0) begin
          w_nextState = ST_RUN;
        end
      end
    endcase
  end

  // The watchdog counter saturates at TIMEOUT so it cannot wrap back below it.
  assign w_waitNext = (r_state != ST_MEM_WAIT) ? '0 :
                      (r_wait == WAIT_MAX)     ? r_wait : r_wait + WW'(1);

  // State, init countdown, performance counters and the sticky watchdog flag.
  always_ff @(posedge i_hz_clk or posedge i_hz_rst) begin
    if (i_hz_rst) begin
      r_state    <= ST_INIT;
      r_initCnt  <= INIT_LOAD;
      r_wait     <= '0;
      r_stallCnt <= '0;
      r_flushCnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_INIT && r_initCnt != '0) begin
        r_initCnt <= r_initCnt - IW'(1);
      end
      r_wait <= w_waitNext;
      if (w_waitNext == WAIT_MAX) begin
        r_timeout <= 1'b1;
      end
      if (r_state != ST_INIT && w_pcEnN && r_stallCnt != '1) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (w_redirTaken && r_flushCnt != '1) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
    end
  end

  assign o_hz_pc_en_n     = w_pcEnN;
  assign o_hz_ifid_en_n   = w_ifidEnN;
  assign o_hz_idex_en_n   = w_idexEnN;
  assign o_hz_exmem_en_n  = w_exmemEnN;
  assign o_hz_memwb_en_n  = w_memwbEnN;
  assign o_hz_ifid_clr    = w_ifidClr;
  assign o_hz_idex_clr    = w_idexClr;
  assign o_hz_exmem_clr   = w_exmemClr;
  assign o_hz_memwb_clr   = w_memwbClr;
  assign o_hz_state       = r_state;
  assign o_hz_stall_cnt   = r_stallCnt;
  assign o_hz_flush_cnt   = r_flushCnt;
  assign o_hz_mem_timeout = r_timeout;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Every cycle it drives the clear and active-low enable controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It handles a post-reset flush, load-use stalls, branch/jump redirects, and multi-cycle data-memory waits with a watchdog. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- INIT_CYCLES, 2, number of cycles after reset during which all pipeline registers are held cleared (≥1)
- TIMEOUT, 255, number of MEM_WAIT cycles after which the watchdog flag sets (≥1)
- CNT_W, 16, width of the performance counters

Ports (one clock; reset is asynchronous and active-high):
- i_hz_clk  in  1  core clock, rising edge
- i_hz_rst  in  1  asynchronous active-high reset
- i_hz_id_rs1, i_hz_id_rs2  in  5  source register indices of the instruction in ID
- i_hz_id_uses_rs1, i_hz_id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- i_hz_ex_rd  in  5  destination register of the instruction in EX
- i_hz_ex_is_load  in  1  the EX instruction is a load
- i_hz_ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- i_hz_dmem_req  in  1  MEM stage holds a valid load/store
- i_hz_dmem_ready  in  1  data memory completes the access this cycle
- o_hz_pc_en_n  out  1  PC update enable, active-low
- o_hz_ifid_en_n, o_hz_idex_en_n, o_hz_exmem_en_n, o_hz_memwb_en_n  out  1  stage enables, active-low
- o_hz_ifid_clr, o_hz_idex_clr, o_hz_exmem_clr, o_hz_memwb_clr  out  1  synchronous stage clears (a clear overrides the enable at the register)
- o_hz_state  out  2  FSM state: INIT=0, RUN=1, MEM_WAIT=2
- o_hz_stall_cnt  out  CNT_W  count of stall cycles
- o_hz_flush_cnt  out  CNT_W  count of redirect flushes
- o_hz_mem_timeout  out  1  sticky watchdog flag

## Operation
- The FSM state and counters are registered. The control outputs are combinational, computed from the current state and the current inputs (Mealy).
- **INIT**
  - All four clr signals = 1.
  - All en_n signals = 1, including o_hz_pc_en_n.
  - The init counter starts at INIT_CYCLES-1 and decrements each cycle. At 0 the FSM moves to RUN.
- **RUN and MEM_WAIT** evaluate the hazards in this priority order:
  1. **Freeze**, when i_hz_dmem_req && !i_hz_dmem_ready:
     - pc/ifid/idex/exmem en_n = 1.
     - memwb_en_n = 0 and memwb_clr = 1, so a bubble enters WB.
     - All other clr = 0.
  2. **Redirect**, when i_hz_ex_redirect:
     - ifid_clr = 1, idex_clr = 1.
     - All en_n = 0, so the PC loads the target.
  3. **Load-use**, when i_hz_ex_is_load && i_hz_ex_rd≠0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)):
     - pc_en_n = 1, ifid_en_n = 1.
     - idex_clr = 1.
     - All other controls at their defaults.
  4. **Otherwise**: all en_n = 0 and all clr = 0.
- A redirect that coincides with a freeze is not lost. EX is frozen, so i_hz_ex_redirect stays asserted until the freeze ends.
- **Transitions**:
  - RUN→MEM_WAIT on a freeze condition.
  - MEM_WAIT→RUN on the cycle i_hz_dmem_ready=1. That cycle produces the normal non-freeze outputs.
  - MEM_WAIT→MEM_WAIT otherwise.
- **stall_cnt** increments on every RUN/MEM_WAIT cycle with pc_en_n=1, which covers both freeze and load-use. It saturates at all-ones.
- **flush_cnt** increments on every cycle where the redirect branch is taken (priority 2 above). It saturates at all-ones.
- **Watchdog**:
  - The wait counter is $clog2(TIMEOUT+1) bits wide. It increments each cycle the FSM is in MEM_WAIT and clears otherwise.
  - When it reaches TIMEOUT, o_hz_mem_timeout sets. The flag stays set until reset.

## Timing
- **Reset values**:
  - state = INIT, init counter = INIT_CYCLES-1.
  - stall_cnt = 0, flush_cnt = 0, wait counter = 0, o_hz_mem_timeout = 0.
  - While reset is asserted the outputs show the INIT pattern: all clr=1, all en_n=1.
- INIT lasts exactly INIT_CYCLES rising edges after reset deasserts. The first RUN cycle follows immediately.
- Control outputs have zero latency: they respond to input changes in the same cycle.
- Load-use produces one bubble. In the next cycle the load is in MEM, the condition is false, and the pipeline proceeds.
- A freeze lasting N cycles adds N to stall_cnt and inserts N bubbles into WB. The ready cycle itself is not counted.
- Reset asserted in the middle of any state immediately forces the INIT outputs and clears all counters and the flag.
- Counters hold at 2^CNT_W-1 with no wrap-around.

## Test plan
- **Reset/INIT** (defaults): pulse i_hz_rst → all clr=1 and all en_n=1 for exactly 2 cycles after deassert; then all 0 and o_hz_state=1; all counters 0.
- **Load-use**: ex_is_load=1, ex_rd=5, id_rs2=5, uses_rs2=1 for one cycle → pc_en_n=1, ifid_en_n=1, idex_clr=1; stall_cnt goes 0→1. Repeat with ex_rd=0 → no stall, stall_cnt unchanged.
- **Redirect beats load-use**: redirect=1 together with the load-use condition → ifid_clr=1, idex_clr=1, pc_en_n=0; flush_cnt+1; stall_cnt unchanged.
- **Memory wait**: dmem_req=1 with dmem_ready=0 for 3 cycles, then ready=1 →
  - freeze pattern with memwb_clr=1 for 3 cycles;
  - o_hz_state=2 on cycles 2-3;
  - stall_cnt+3;
  - normal outputs and return to RUN on the ready cycle.
- **Watchdog** (TIMEOUT=4): hold req=1, ready=0 → o_hz_mem_timeout=1 after the 4th MEM_WAIT cycle; it stays 1 after ready arrives and clears only on reset.
- **Reset mid-MEM_WAIT** with stall_cnt=7 → INIT outputs in the same cycle; stall_cnt=0, o_hz_mem_timeout=0, o_hz_state=0.
